// File: rtl/genesis_gamepads_multi.sv
// Multi-port Sega Genesis / Mega Drive gamepad reader: drives SELECT through an
// 8-phase poll, identifies each pad type and commits all decoded buttons per frame.
module genesis_gamepads_multi #(
  parameter int NUM_PADS      = 2,
  parameter int SETTLE_CYCLES = 100,
  parameter int POLL_CYCLES   = 100000
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iENABLE,
  input  logic [6*NUM_PADS-1:0]   iGENPAD,
  output logic [NUM_PADS-1:0]     oGENPAD_SELECT,
  output logic [2*NUM_PADS-1:0]   oGENPAD_TYPE,
  output logic [12*NUM_PADS-1:0]  oGENPAD_DECODED,
  output logic                    oUPDATE
);

  localparam int TMAX = (POLL_CYCLES > SETTLE_CYCLES) ? POLL_CYCLES : SETTLE_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] POLL_TC   = TW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_TC = TW'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {IDLE, P0, P1, P2, P3, P4, P5, P6, P7} state_t;

  state_t                     state_q, state_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic                       phase_end;
  logic                       sel_q, sel_d;
  logic                       update_q;
  logic [6*NUM_PADS-1:0]      sync1_q, sync2_q;
  logic [NUM_PADS-1:0][5:0]   pad_s;
  logic [NUM_PADS-1:0]        err_q, is3_q, is6_q;
  logic [NUM_PADS-1:0][11:0]  shadow_q, dec_q;
  logic [NUM_PADS-1:0][1:0]   type_q;

  // Pins are active-low; work with pressed = 1 from here on.
  assign pad_s = ~sync2_q;

  assign oGENPAD_SELECT  = {NUM_PADS{sel_q}};
  assign oGENPAD_TYPE    = type_q;
  assign oGENPAD_DECODED = dec_q;
  assign oUPDATE         = update_q;

  always_comb begin
    phase_end = (state_q == IDLE) ? (timer_q == POLL_TC) : (timer_q == SETTLE_TC);
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    if (phase_end) begin
      timer_d = '0;
      case (state_q)
        IDLE:    state_d = iENABLE ? P0 : IDLE;
        P7:      state_d = IDLE;
        default: state_d = state_t'(state_q + 4'd1);
      endcase
    end
    case (state_d)
      P1, P3, P5, P7: sel_d = 1'b0;
      default:        sel_d = 1'b1;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      sel_q    <= 1'b1;
      update_q <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      err_q    <= '0;
      is3_q    <= '0;
      is6_q    <= '0;
      shadow_q <= '0;
      dec_q    <= '0;
      type_q   <= '0;
    end else begin
      sync1_q  <= iGENPAD;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      timer_q  <= timer_d;
      sel_q    <= sel_d;
      update_q <= phase_end && (state_q == P7);
      if (phase_end) begin
        for (int n = 0; n < NUM_PADS; n++) begin
          case (state_q)
            P0: begin
              shadow_q[n][6]   <= pad_s[n][5];
              shadow_q[n][5]   <= pad_s[n][4];
              shadow_q[n][3:0] <= pad_s[n][3:0];
              err_q[n]         <= &pad_s[n][3:0];
            end
            P1: begin
              is3_q[n]       <= &pad_s[n][1:0];
              shadow_q[n][7] <= pad_s[n][5];
              shadow_q[n][4] <= pad_s[n][4];
            end
            P5: is6_q[n] <= is3_q[n] & (&pad_s[n][3:0]);
            P6: if (is6_q[n]) shadow_q[n][11:8] <= pad_s[n][3:0];
            P7: begin
              if (err_q[n])      type_q[n] <= 2'd3;
              else if (is6_q[n]) type_q[n] <= 2'd2;
              else if (is3_q[n]) type_q[n] <= 2'd1;
              else               type_q[n] <= 2'd0;
              // An erroring pad keeps its last good button word.
              if (!err_q[n])
                dec_q[n] <= {shadow_q[n][11:8] & {4{is6_q[n]}},
                             shadow_q[n][7] & is3_q[n],
                             shadow_q[n][6:5],
                             shadow_q[n][4] & is3_q[n],
                             shadow_q[n][3:0]};
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/genesis_gamepads_multi.md
# genesis_gamepads_multi

Parametrised multi-port Sega Genesis/Mega Drive gamepad reader for the DE2-115 board glue. It drives the SELECT line of up to NUM_PADS ports through a timed 8-phase polling sequence. It identifies each pad as Master System, 3-button or 6-button. It publishes active-high decoded buttons for all pads atomically once per frame. Inputs are asynchronous board pins and are synchronised internally.

## Interface
- NUM_PADS, 2: number of pad ports, 1..4.
- SETTLE_CYCLES, 100: clocks per SELECT phase (2 us at 50 MHz); must be ≥4.
- POLL_CYCLES, 100000: idle clocks between frames, with SELECT high (2 ms at 50 MHz); must be ≥1.5 ms worth so 6-button pads reset their phase counter.
- iCLK  in  1  system clock.
- iRESET  in  1  reset; one clock, asynchronous, active-high.
- iENABLE  in  1  polling enable, sampled only at the end of IDLE.
- iGENPAD  in  6*NUM_PADS  raw pad pins, active-low; pad n at [6n+5:6n] = {C/Start, B/A, Up/Z, Down/Y, Left/X, Right/Mode}.
- oGENPAD_SELECT  out  NUM_PADS  SELECT per port; all bits are always identical.
- oGENPAD_TYPE  out  2*NUM_PADS  per pad: 0 MasterSystem/none, 1 3-button, 2 6-button, 3 error.
- oGENPAD_DECODED  out  12*NUM_PADS  per pad, active-high {Z,Y,X,M,S,C,B,A,U,D,L,R}.
- oUPDATE  out  1  one-clock pulse when outputs change to a new frame.

## Operation
- Every iGENPAD bit passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- States: IDLE, P0..P7. The phase timer counts 0..SETTLE_CYCLES-1 within Pk and 0..POLL_CYCLES-1 in IDLE.
- SELECT value: high in IDLE, P0, P2, P4 and P6; low in P1, P3, P5 and P7. It is registered and changes on the first clock of a phase.
- Sampling happens on the last clock of each phase. Per-pad captures (s = inverted synchronised input):
  - P0: C=s[5], B=s[4], U=s[3], D=s[2], L=s[1], R=s[0]. Set err when s[3:0]==4'hF, i.e. all directions pressed.
  - P1: is3 when s[1:0]==2'b11; S=s[5], A=s[4].
  - P5: is6 when is3 and s[3:0]==4'hF.
  - P6: if is6, Z=s[3], Y=s[2], X=s[1], M=s[0].
  - P2, P3, P4 and P7 are clocked but not captured.
- Pads without is3: S, A, Z, Y, X and M are reported 0. Without is6: Z, Y, X and M are reported 0.
- Type per pad: err→3; else is6→2; else is3→1; else 0.
- A pad with err keeps its previous oGENPAD_DECODED word; only its type is updated.
- Commit: on the last clock of P7, all pads' shadow registers are copied to the outputs together. oUPDATE is high for that clock; the FSM then goes to IDLE.
- End of IDLE: iENABLE=1 → P0; iENABLE=0 → stay in IDLE and restart the IDLE timer. Outputs hold their values.
- iENABLE has no effect mid-frame.
- Pads are independent. Mixed pad types in one frame are legal.

## Timing
- Frame period = POLL_CYCLES + 8*SETTLE_CYCLES clocks.
- Input-to-capture latency: 2 clocks of synchroniser, then the sample at the phase end. The effective pad settle time is SETTLE_CYCLES-2.
- Outputs change only on commit. Any press is reflected within two frames.
- Reset values (asynchronous, while iRESET=1):
  - FSM in IDLE, timer 0.
  - oGENPAD_SELECT all 1.
  - oGENPAD_TYPE 0, oGENPAD_DECODED 0, oUPDATE 0.
  - Shadows and synchronisers 0.
- Reset released mid-frame: the sequence restarts from IDLE, and the first commit comes a full frame later.
- Timer wrap: the timer reaching its terminal count triggers the phase advance and resets the timer to 0 on the same clock.

## Test plan
Parameters for all scenarios: SETTLE_CYCLES=4, POLL_CYCLES=20, NUM_PADS=2.
- Reset/idle: hold iRESET for 3 clocks → SELECT=2'b11, TYPE=0, DECODED=0. First oUPDATE arrives at clock 20+32 after release, with iENABLE=1.
- 3-button model on pad0 with A+Up pressed → TYPE[1:0]=1, DECODED[11:0]=12'h018. SELECT toggles every 4 clocks during P0..P7.
- 6-button model on pad1 (phase counter reset after idle) with Z+Start pressed → TYPE[3:2]=2, DECODED[23:12]=12'h880.
- Pad0 with no pad (all inputs high) → TYPE=0, DECODED=0. Then a Master System pad pressing button 1 (bit4 low in all phases) → TYPE=0, DECODED=12'h020.
- Error case: pad0 forces s[3:0]=F in P0 → TYPE=3, DECODED holds its prior value. Meanwhile pad1 decodes normally in the same frame.
- iENABLE=0 asserted during P3 → the current frame completes with oUPDATE. No further oUPDATE occurs and SELECT stays high. Re-enable → the next frame starts at the end of the following IDLE.
- Asserting iRESET during P5 → all outputs are 0 and SELECT=1 on the same clock, asynchronously.
